// File: rtl/tdm_demultiplexer_pkg.sv
// rtl/tdm_demultiplexer_pkg.sv - shared constants and FSM state encoding
//
// Purpose : default frame geometry (channels per frame, bits per slot) and
//           the two-state FSM encoding shared by the demultiplexer and its bench.
// Ports   : none (package).
package tdm_demultiplexer_pkg;

   localparam int N_CH = 4;
   localparam int W    = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_demultiplexer_if.sv
// rtl/tdm_demultiplexer_if.sv - serial-in / parallel-out bundle of the demultiplexer
//
// Purpose : groups the serial line, frame sync and the demultiplexed outputs.
// Signals : x     - serial time-multiplexed data bit
//           sync  - high on the first bit of a frame
//           z     - N_CH*W demultiplexed channels, channel k at z[k*W +: W]
//           valid - one-cycle pulse when z takes a complete frame
//           err   - one-cycle pulse when a frame is aborted by an early sync
// Modports: master drives x/sync, slave (the demultiplexer) drives z/valid/err.
interface tdm_demultiplexer_if #(
   parameter int N_CH = tdm_demultiplexer_pkg::N_CH,
   parameter int W    = tdm_demultiplexer_pkg::W
) ();

   logic                x;
   logic                sync;
   logic [N_CH*W-1:0]   z;
   logic                valid;
   logic                err;

   modport master (output x, output sync, input z, input valid, input err);
   modport slave  (input x, input sync, output z, output valid, output err);

endinterface

// File: rtl/tdm_demultiplexer_b2to4_decoder.sv
// rtl/tdm_demultiplexer_b2to4_decoder.sv - 2-to-4 one-hot decoder with enable
//
// Purpose : turns the channel counter into the shadow-register write enables,
//           active only when the end-of-slot strobe is high.
// Ports   : sel - 2-bit channel index
//           en  - end-of-slot strobe
//           dec - one-hot write enables (all zero while en=0)
module b2to4_decoder (
   input  logic [1:0] sel,
   input  logic       en,
   output logic [3:0] dec
);

   always_comb begin
      dec = 4'b0000;
      if (en) begin
         dec = 4'b0001 << sel;
      end
   end

endmodule

// File: rtl/tdm_demultiplexer.sv
// rtl/tdm_demultiplexer.sv - serial TDM frame to parallel channel demultiplexer
//
// Purpose : samples one bit of x per clock, assembles N_CH slots of W bits
//           (channel 0 first, MSB first), publishes a complete frame on z with
//           a one-cycle valid pulse, and flags frames cut short by a new sync.
// Ports   : clock  - rising-edge clock
//           reset_ - asynchronous active-low reset
//           bus    - slave side of tdm_demultiplexer_if (x, sync in; z, valid, err out)
module tdm_demultiplexer
   import tdm_demultiplexer_pkg::*;
#(
   parameter int N_CH = tdm_demultiplexer_pkg::N_CH,
   parameter int W    = tdm_demultiplexer_pkg::W
) (
   input  logic                  clock,
   input  logic                  reset_,
   tdm_demultiplexer_if.slave    bus
);

   localparam int FW = N_CH * W;
   localparam int BW = (W > 1)    ? $clog2(W)    : 1;
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   state_t            state;
   logic [BW-1:0]     bit_cnt;
   logic [CW-1:0]     ch_cnt;
   logic [W-1:0]      shift;
   logic [FW-1:0]     shadow;
   logic [FW-1:0]     z_q;
   logic              valid_q;
   logic              err_q;

   logic              sample;
   logic              last_bit;
   logic              last_ch;
   logic              abort;
   logic              slot_end;
   logic [W-1:0]      new_word;
   logic [N_CH-1:0]   wr_en;
   logic [FW-1:0]     frame_next;

   always_comb begin
      // In IDLE the counters are zero, so a sync there can never look like an abort.
      sample   = (state == SHIFT) || bus.sync;
      last_bit = (bit_cnt == BW'(W - 1));
      last_ch  = (ch_cnt == CW'(N_CH - 1));
      // A sync on the final bit lets the frame finish; anywhere else in SHIFT it aborts.
      abort    = (state == SHIFT) && bus.sync && !(last_bit && last_ch);
      slot_end = sample && !abort && last_bit;
      new_word = {shift[W-2:0], bus.x};
   end

   generate
      if (N_CH == 4) begin : g_dec4
         b2to4_decoder u_dec (
            .sel (ch_cnt),
            .en  (slot_end),
            .dec (wr_en)
         );
      end else begin : g_dec_generic
         assign wr_en = slot_end ? (N_CH'(1) << ch_cnt) : '0;
      end
   endgenerate

   // The finishing slot is merged in combinationally so z can be loaded on the
   // same edge that samples the final bit, without waiting for the shadow write.
   always_comb begin
      frame_next = shadow;
      for (int k = 0; k < N_CH; k++) begin
         if (wr_en[k]) begin
            frame_next[k*W +: W] = new_word;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state   <= IDLE;
         bit_cnt <= '0;
         ch_cnt  <= '0;
         shift   <= '0;
         shadow  <= '0;
         z_q     <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         if (sample) begin
            shift <= new_word;
            if (abort) begin
               // The sync-cycle bit becomes bit 0 of the replacement frame.
               err_q   <= 1'b1;
               bit_cnt <= BW'(1);
               ch_cnt  <= '0;
               state   <= SHIFT;
            end else if (last_bit) begin
               bit_cnt <= '0;
               shadow  <= frame_next;
               if (last_ch) begin
                  ch_cnt  <= '0;
                  z_q     <= frame_next;
                  valid_q <= 1'b1;
                  state   <= IDLE;
               end else begin
                  ch_cnt <= ch_cnt + CW'(1);
                  state  <= SHIFT;
               end
            end else begin
               bit_cnt <= bit_cnt + BW'(1);
               state   <= SHIFT;
            end
         end
      end
   end

   assign bus.z     = z_q;
   assign bus.valid = valid_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// tb/tb_tdm_demultiplexer.sv - directed self-checking bench for tdm_demultiplexer
//
// Purpose : drives directed frames on x/sync and checks z/valid/err against
//           hand-computed values one step after each sampling edge.
// Ports   : none (top-level bench).
module tb_tdm_demultiplexer;
   import tdm_demultiplexer_pkg::*;

   localparam int FW = N_CH * W;

   logic clock = 1'b0;
   logic reset_;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   c1;
   int   c2;
   int   seen;

   tdm_demultiplexer_if #(.N_CH(N_CH), .W(W)) bus ();

   tdm_demultiplexer #(.N_CH(N_CH), .W(W)) dut (
      .clock  (clock),
      .reset_ (reset_),
      .bus    (bus.slave)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Frame bit i: channel i/W, MSB first within the slot.
   function automatic logic frame_bit(input logic [FW-1:0] d, input int i);
      return d[(i / W) * W + (W - 1 - (i % W))];
   endfunction

   task automatic send_bit(input logic xb, input logic sb);
      bus.x    = xb;
      bus.sync = sb;
      @(posedge clock);
      #1;
   endtask

   task automatic send_bits(input logic [FW-1:0] d, input int first, input int count,
                            input logic sync_final);
      for (int i = first; i < first + count; i++) begin
         send_bit(frame_bit(d, i), (i == 0) || (sync_final && (i == FW - 1)));
      end
   endtask

   initial begin
      reset_   = 1'b0;
      bus.x    = 1'b0;
      bus.sync = 1'b0;
      #1;
      chk("reset_z",     bus.z,     '0);
      chk("reset_valid", FW'(bus.valid), '0);
      chk("reset_err",   FW'(bus.err),   '0);
      @(posedge clock);
      #1;
      reset_ = 1'b1;

      // Basic frame A5,3C,FF,01
      send_bits(32'h01FF3CA5, 0, FW, 1'b0);
      chk("f1_valid", FW'(bus.valid), FW'(1));
      chk("f1_z",     bus.z,          32'h01FF3CA5);
      chk("f1_err",   FW'(bus.err),   '0);
      send_bit(1'b0, 1'b0);
      chk("f1_valid_pulse", FW'(bus.valid), '0);
      chk("f1_z_hold",      bus.z,          32'h01FF3CA5);

      // Toggling x with no sync while idle
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         send_bit(i[0], 1'b0);
         if (bus.valid || bus.err) seen++;
      end
      chk("idle_pulses", FW'(seen), '0);
      chk("idle_z",      bus.z,     32'h01FF3CA5);

      // Abort by a second sync at bit 13, which starts frame 11,22,33,44
      send_bits(32'hDEADBEEF, 0, 13, 1'b0);
      send_bits(32'h44332211, 0, 1, 1'b0);
      chk("abort_err",   FW'(bus.err),   FW'(1));
      chk("abort_valid", FW'(bus.valid), '0);
      chk("abort_z",     bus.z,          32'h01FF3CA5);
      send_bits(32'h44332211, 1, 1, 1'b0);
      chk("abort_err_pulse", FW'(bus.err), '0);
      send_bits(32'h44332211, 2, FW - 2, 1'b0);
      chk("after_abort_valid", FW'(bus.valid), FW'(1));
      chk("after_abort_z",     bus.z,          32'h44332211);
      chk("after_abort_err",   FW'(bus.err),   '0);

      // Back-to-back frames 00,00,00,80 then 7F,00,00,00
      send_bits(32'h80000000, 0, FW, 1'b0);
      chk("b2b1_valid", FW'(bus.valid), FW'(1));
      chk("b2b1_z",     bus.z,          32'h80000000);
      c1 = cyc;
      send_bits(32'h0000007F, 0, FW, 1'b0);
      chk("b2b2_valid", FW'(bus.valid), FW'(1));
      chk("b2b2_z",     bus.z,          32'h0000007F);
      chk("b2b2_err",   FW'(bus.err),   '0);
      c2 = cyc;
      chk("b2b_gap", FW'(c2 - c1), FW'(32));

      // Reset pulled low at bit 20 of a frame
      send_bits(32'hA5A5A5A5, 0, 20, 1'b0);
      #2;
      reset_   = 1'b0;
      bus.sync = 1'b0;
      #1;
      chk("midreset_z",     bus.z,          '0);
      chk("midreset_valid", FW'(bus.valid), '0);
      chk("midreset_err",   FW'(bus.err),   '0);
      @(posedge clock);
      #1;
      reset_ = 1'b1;
      send_bits(32'h12345678, 0, FW, 1'b0);
      chk("postreset_valid", FW'(bus.valid), FW'(1));
      chk("postreset_z",     bus.z,          32'h12345678);
      chk("postreset_err",   FW'(bus.err),   '0);

      // Sync on the final bit completes the frame and returns to IDLE
      send_bits(32'hCAFEBABE, 0, FW, 1'b1);
      chk("syncfinal_valid", FW'(bus.valid), FW'(1));
      chk("syncfinal_err",   FW'(bus.err),   '0);
      chk("syncfinal_z",     bus.z,          32'hCAFEBABE);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         send_bit(1'b1, 1'b0);
         if (bus.valid || bus.err) seen++;
      end
      chk("syncfinal_idle", FW'(seen), '0);
      send_bits(32'h0F0F0F0F, 0, 1, 1'b0);
      chk("fresh_no_abort", FW'(bus.err), '0);
      send_bits(32'h0F0F0F0F, 1, FW - 1, 1'b0);
      chk("fresh_valid", FW'(bus.valid), FW'(1));
      chk("fresh_z",     bus.z,          32'h0F0F0F0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
